// File: rtl/packet_parity_if.sv
// Beat-in / result-out handshake bundle for the packet parity accumulator.
// The slave side is the accumulator; the master side feeds beats and takes results.
interface packet_parity_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_parity;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_parity, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_parity, out_count, out_ovf
    );
endinterface

// File: rtl/packet_parity_acc.sv
// Accumulates per-packet parity and beat count, then holds one result until the
// consumer takes it. Input is stalled while a result is pending.
module packet_parity_acc #(
    parameter int W    = 8,
    parameter int ODD  = 0,
    parameter int MAXB = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    packet_parity_if.slave  bus
);
    localparam int             CW      = $clog2(MAXB + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAXB);
    localparam logic           ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t         state_reg;
    logic           in_ready_reg;
    logic           out_valid_reg;
    logic           out_parity_reg;
    logic           run_par_reg;
    logic           ovf_reg;
    logic [CW-1:0]  count_reg;
    logic           accept;
    logic           beat_par;

    assign accept   = bus.in_valid && in_ready_reg;
    assign beat_par = ^bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_parity_reg <= 1'b0;
            run_par_reg    <= 1'b0;
            ovf_reg        <= 1'b0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        run_par_reg <= beat_par;
                        count_reg   <= CW'(1);
                        ovf_reg     <= 1'b0;
                        if (bus.in_last) begin
                            state_reg      <= DONE;
                            out_valid_reg  <= 1'b1;
                            in_ready_reg   <= 1'b0;
                            out_parity_reg <= beat_par ^ ODD_BIT;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        run_par_reg <= run_par_reg ^ beat_par;
                        // Counter saturates; the beat that would push it past MAXB flags overflow.
                        if (count_reg == MAX_CNT) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CW'(1);
                        end
                        if (bus.in_last) begin
                            state_reg      <= DONE;
                            out_valid_reg  <= 1'b1;
                            in_ready_reg   <= 1'b0;
                            out_parity_reg <= run_par_reg ^ beat_par ^ ODD_BIT;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg      <= IDLE;
                        out_valid_reg  <= 1'b0;
                        in_ready_reg   <= 1'b1;
                        out_parity_reg <= 1'b0;
                        run_par_reg    <= 1'b0;
                        ovf_reg        <= 1'b0;
                        count_reg      <= '0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_parity = out_parity_reg;
    assign bus.out_count  = count_reg;
    assign bus.out_ovf    = ovf_reg;
endmodule

// File: tb/tb_packet_parity_acc.sv
// Drives three accumulator configurations in lockstep from one stimulus stream and
// checks them against a packet-level reference (bit counts, one-slot result buffer).
module tb_packet_parity_acc;
    localparam int NPKT = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_parity_if #(.W(8), .CW(8)) bus0 ();
    packet_parity_if #(.W(8), .CW(8)) bus1 ();
    packet_parity_if #(.W(8), .CW(2)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus0.in_data = in_data;
    assign bus0.in_last  = in_last;   assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;  assign bus1.in_data = in_data;
    assign bus1.in_last  = in_last;   assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.in_data = in_data;
    assign bus2.in_last  = in_last;   assign bus2.out_ready = out_ready;

    packet_parity_acc #(.W(8), .ODD(0), .MAXB(255)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    packet_parity_acc #(.W(8), .ODD(1), .MAXB(255)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    packet_parity_acc #(.W(8), .ODD(0), .MAXB(3))   dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic       ir [3];
    logic       ov [3];
    logic       op [3];
    logic       oo [3];
    logic [7:0] oc [3];

    assign ir[0] = bus0.in_ready;   assign ir[1] = bus1.in_ready;   assign ir[2] = bus2.in_ready;
    assign ov[0] = bus0.out_valid;  assign ov[1] = bus1.out_valid;  assign ov[2] = bus2.out_valid;
    assign op[0] = bus0.out_parity; assign op[1] = bus1.out_parity; assign op[2] = bus2.out_parity;
    assign oo[0] = bus0.out_ovf;    assign oo[1] = bus1.out_ovf;    assign oo[2] = bus2.out_ovf;
    assign oc[0] = bus0.out_count;  assign oc[1] = bus1.out_count;  assign oc[2] = {6'd0, bus2.out_count};

    typedef struct packed {
        logic [2:0]      par;
        logic [2:0]      ovf;
        logic [2:0][7:0] cnt;
    } exp_t;

    function automatic int odd_of(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int maxb_of(int k);
        return (k == 2) ? 3 : 255;
    endfunction

    // Expected result for a packet with the given total of set bits and beat count.
    function automatic exp_t expect_pkt(int ones, int n);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.par[k] = 1'((ones % 2) ^ odd_of(k));
            e.cnt[k] = 8'((n > maxb_of(k)) ? maxb_of(k) : n);
            e.ovf[k] = (n > maxb_of(k));
        end
        return e;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = ir[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_beat: beat %h not accepted within 50 cycles (in_ready=%b, required 1)", d, ir[0]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || op[k] !== 1'b0 || oc[k] !== 8'd0 || oo[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b par=%b cnt=%0d ovf=%b, required 1 0 0 0 0",
                         k, ir[k], ov[k], op[k], oc[k], oo[k]);
            end
        end
        $display("reset: outputs sampled in reset");
    endtask

    task automatic test_single();
        exp_t e = expect_pkt($countones(8'hA5), 1);
        out_ready = 1'b0;
        send_beat(8'hA5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                errors++;
                $display("FAIL single dut%0d: vld=%b rdy=%b par=%b cnt=%0d ovf=%b, required 1 0 %b %0d %b",
                         k, ov[k], ir[k], op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
            end
        end
        $display("single: beat A5 -> par0=%b cnt0=%0d", op[0], oc[0]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_odd_three();
        exp_t e = expect_pkt($countones(8'h01) + $countones(8'h03) + $countones(8'h07), 3);
        out_ready = 1'b1;
        send_beat(8'h01, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h07, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                errors++;
                $display("FAIL three_beat dut%0d: vld=%b par=%b cnt=%0d ovf=%b, required 1 %b %0d %b",
                         k, ov[k], op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
            end
        end
        $display("three_beat: 01 03 07 -> par1=%b cnt1=%0d", op[1], oc[1]);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL three_beat_idle dut%0d: vld=%b rdy=%b, required 0 1", k, ov[k], ir[k]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e = expect_pkt($countones(8'h3C) + $countones(8'h0E), 2);
        out_ready = 1'b0;
        send_beat(8'h3C, 1'b0);
        send_beat(8'h0E, 1'b1);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== 1'b0 || ov[k] !== 1'b1 || op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                    errors++;
                    $display("FAIL backpressure c%0d dut%0d: rdy=%b vld=%b par=%b cnt=%0d ovf=%b, required 0 1 %b %0d %b",
                             c, k, ir[k], ov[k], op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
                end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || oc[k] !== 8'd0) begin
                errors++;
                $display("FAIL backpressure_release dut%0d: rdy=%b vld=%b cnt=%0d, required 1 0 0", k, ir[k], ov[k], oc[k]);
            end
        end
        $display("backpressure: 5 stalled cycles, released");
    endtask

    task automatic test_overflow();
        exp_t e = expect_pkt(5, 5);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(8'h01, (i == 4));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                errors++;
                $display("FAIL overflow dut%0d: vld=%b par=%b cnt=%0d ovf=%b, required 1 %b %0d %b",
                         k, ov[k], op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
            end
        end
        $display("overflow: 5 x 01 -> cnt2=%0d ovf2=%b par2=%b", oc[2], oo[2], op[2]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e = expect_pkt($countones(8'h80), 1);
        int seen = 0;
        out_ready = 1'b0;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || oc[k] !== 8'd0 || op[k] !== 1'b0 || oo[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: rdy=%b vld=%b cnt=%0d par=%b ovf=%b, required 1 0 0 0 0",
                         k, ir[k], ov[k], oc[k], op[k], oo[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(8'h80, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                errors++;
                $display("FAIL reset_fresh dut%0d: vld=%b par=%b cnt=%0d ovf=%b, required 1 %b %0d %b",
                         k, ov[k], op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov[0] && out_ready) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL reset_result_count: results=%0d, required 1", seen);
        end
        $display("reset_mid: partial packet dropped, fresh 80 -> par0=%b, results=%0d", e.par[0], seen);
    endtask

    task automatic test_random();
        logic [7:0] pkt[$];
        exp_t       exp_q[$];
        exp_t       cur;
        exp_t       e;
        int         idx = 0;
        int         n_sent = 0;
        int         n_done = 0;
        bit         pending = 0;
        bit         hold_v = 0;
        logic       hp [3];
        logic       ho [3];
        logic [7:0] hc [3];
        for (int cyc = 0; cyc < 80000 && n_done < NPKT; cyc++) begin
            if (idx == pkt.size() && n_sent < NPKT) begin
                int len  = ($urandom_range(0, 39) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 6);
                int ones = 0;
                pkt.delete();
                for (int i = 0; i < len; i++) begin
                    logic [7:0] d = 8'($urandom);
                    pkt.push_back(d);
                    ones += $countones(d);
                end
                cur = expect_pkt(ones, len);
                idx = 0;
                n_sent++;
            end
            if (idx < pkt.size()) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = pkt[idx];
                in_last  = (idx == pkt.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== !pending || ov[k] !== pending) begin
                    errors++;
                    $display("FAIL random_handshake cyc%0d dut%0d: rdy=%b vld=%b, required %b %b",
                             cyc, k, ir[k], ov[k], !pending, pending);
                end
                if (hold_v) begin
                    checks++;
                    if (op[k] !== hp[k] || oc[k] !== hc[k] || oo[k] !== ho[k]) begin
                        errors++;
                        $display("FAIL random_stable cyc%0d dut%0d: par=%b cnt=%0d ovf=%b, required %b %0d %b",
                                 cyc, k, op[k], oc[k], oo[k], hp[k], hc[k], ho[k]);
                    end
                end
                hp[k] = op[k]; hc[k] = oc[k]; ho[k] = oo[k];
            end
            hold_v = pending && !out_ready;
            if (pending && out_ready) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (op[k] !== e.par[k] || oc[k] !== e.cnt[k] || oo[k] !== e.ovf[k]) begin
                        errors++;
                        $display("FAIL random_result pkt%0d dut%0d: par=%b cnt=%0d ovf=%b, required %b %0d %b",
                                 n_done, k, op[k], oc[k], oo[k], e.par[k], e.cnt[k], e.ovf[k]);
                    end
                end
                $display("random pkt %0d: par=%b%b%b cnt0=%0d cnt2=%0d ovf2=%b",
                         n_done, op[0], op[1], op[2], oc[0], oc[2], oo[2]);
                n_done++;
                pending = 0;
            end else if (in_valid && !pending) begin
                idx++;
                if (in_last) begin
                    exp_q.push_back(cur);
                    pending = 1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n_done != NPKT) begin
            errors++;
            $display("FAIL random_timeout: results=%0d, required %0d", n_done, NPKT);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_odd_three();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
